// File: rtl/spi_cmd_regs_pkg.sv
// spi_cmd_regs_pkg
//   Shared definitions for the SPI command decoder / register bank:
//   command codes, decoder FSM state encoding, status-byte bit positions
//   and a helper that assembles the status byte.
package spi_cmd_regs_pkg;

  localparam logic [7:0] CMD_RD_PERIOD = 8'h01;
  localparam logic [7:0] CMD_RD_HIGH   = 8'h02;
  localparam logic [7:0] CMD_STATUS    = 8'h03;
  localparam logic [7:0] CMD_WR_GATE   = 8'h10;
  localparam logic [7:0] CMD_START     = 8'h20;

  localparam int unsigned STAT_VALID_BIT = 7;
  localparam int unsigned STAT_BUSY_BIT  = 6;
  localparam int unsigned STAT_ERR_BIT   = 0;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_CMD  = 3'd1,
    ST_TX   = 3'd2,
    ST_WR   = 3'd3,
    ST_PAD  = 3'd4
  } state_e;

  function automatic logic [7:0] status_byte(input logic valid,
                                             input logic busy,
                                             input logic err);
    logic [7:0] s;
    s                 = '0;
    s[STAT_VALID_BIT] = valid;
    s[STAT_BUSY_BIT]  = busy;
    s[STAT_ERR_BIT]   = err;
    return s;
  endfunction

endpackage

// File: rtl/sync_edge.sv
// sync_edge
//   Optional synchronizer chain (DEPTH flops, 0 = input already in the
//   clk domain) followed by a registered edge detector.
//   Ports:
//     clk_i    clock
//     rst_ni   asynchronous active-low reset
//     d_i      input signal
//     level_o  synchronized level (d_i itself when DEPTH = 0)
//     rise_o   one-cycle pulse, registered, after level_o rises
//     fall_o   one-cycle pulse, registered, after level_o falls
module sync_edge #(
  parameter int unsigned DEPTH     = 2,
  parameter logic        RESET_VAL = 1'b0
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  logic prev_q;
  logic rise_q;
  logic fall_q;

  generate
    if (DEPTH == 0) begin : g_direct
      assign level_o = d_i;
    end else if (DEPTH == 1) begin : g_sync1
      logic sync_q;
      always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) sync_q <= RESET_VAL;
        else         sync_q <= d_i;
      end
      assign level_o = sync_q;
    end else begin : g_syncn
      logic [DEPTH-1:0] sync_q;
      always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) sync_q <= {DEPTH{RESET_VAL}};
        else         sync_q <= {sync_q[DEPTH-2:0], d_i};
      end
      assign level_o = sync_q[DEPTH-1];
    end
  endgenerate

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      prev_q <= RESET_VAL;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      prev_q <= level_o;
      rise_q <= level_o & ~prev_q;
      fall_q <= ~level_o & prev_q;
    end
  end

  assign rise_o = rise_q;
  assign fall_o = fall_q;

endmodule

// File: rtl/spi_cmd_regs.sv
// spi_cmd_regs
//   Command decoder and register bank behind the SPI slave. One command
//   byte is decoded per chip-select frame; result/status/padding bytes are
//   presented on txData, the gate-select register is written, and the
//   measurement start pulse is issued.
//   Ports:
//     clk, rest            clock, asynchronous active-low reset
//     cs                   raw SPI chip select (active low, asynchronous)
//     rxData, rxStrobe     received byte and its 8-clk-wide strobe
//     txData               next byte to shift out
//     periodCount,
//     highCount            latest measurement counts (MEAS_WIDTH bits)
//     measValid, measBusy  measurement core status
//     gateSel              gate-time select register
//     measStart            single-cycle measurement start pulse
//     cmdError             sticky unknown-command flag
module spi_cmd_regs
  import spi_cmd_regs_pkg::*;
#(
  parameter int unsigned MEAS_WIDTH = 32,
  parameter logic [7:0]  GATE_RESET = 8'h01
) (
  input  logic                  clk,
  input  logic                  rest,
  input  logic                  cs,
  input  logic [7:0]            rxData,
  input  logic                  rxStrobe,
  output logic [7:0]            txData,
  input  logic [MEAS_WIDTH-1:0] periodCount,
  input  logic [MEAS_WIDTH-1:0] highCount,
  input  logic                  measValid,
  input  logic                  measBusy,
  output logic [7:0]            gateSel,
  output logic                  measStart,
  output logic                  cmdError
);

  localparam int unsigned NBYTES = MEAS_WIDTH / 8;
  localparam int unsigned IDX_W  = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBYTES - 1);

  logic csS;
  logic cs_fall;
  logic cs_rise_unused;
  logic rx_edge;
  logic rx_level_unused;
  logic rx_fall_unused;

  sync_edge #(
    .DEPTH     (2),
    .RESET_VAL (1'b1)
  ) u_cs_sync (
    .clk_i   (clk),
    .rst_ni  (rest),
    .d_i     (cs),
    .level_o (csS),
    .rise_o  (cs_rise_unused),
    .fall_o  (cs_fall)
  );

  sync_edge #(
    .DEPTH     (0),
    .RESET_VAL (1'b0)
  ) u_rx_edge (
    .clk_i   (clk),
    .rst_ni  (rest),
    .d_i     (rxStrobe),
    .level_o (rx_level_unused),
    .rise_o  (rx_edge),
    .fall_o  (rx_fall_unused)
  );

  state_e                state_q,     state_d;
  logic [7:0]            txData_q,    txData_d;
  logic [MEAS_WIDTH-1:0] txBuf_q,     txBuf_d;
  logic [IDX_W-1:0]      byteIdx_q,   byteIdx_d;
  logic [7:0]            gateSel_q,   gateSel_d;
  logic                  measStart_q, measStart_d;
  logic                  cmdError_q,  cmdError_d;

  always_ff @(posedge clk or negedge rest) begin
    if (!rest) begin
      state_q     <= ST_IDLE;
      txData_q    <= '0;
      txBuf_q     <= '0;
      byteIdx_q   <= '0;
      gateSel_q   <= GATE_RESET;
      measStart_q <= 1'b0;
      cmdError_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      txData_q    <= txData_d;
      txBuf_q     <= txBuf_d;
      byteIdx_q   <= byteIdx_d;
      gateSel_q   <= gateSel_d;
      measStart_q <= measStart_d;
      cmdError_q  <= cmdError_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    txData_d    = txData_q;
    txBuf_d     = txBuf_q;
    byteIdx_d   = byteIdx_q;
    gateSel_d   = gateSel_q;
    cmdError_d  = cmdError_q;
    measStart_d = 1'b0;

    // Deselect has priority over everything: a byte whose edge lands in
    // the same cycle as the frame end is dropped.
    if (csS) begin
      state_d   = ST_IDLE;
      txData_d  = '0;
      byteIdx_d = '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (cs_fall) state_d = ST_CMD;
        end
        ST_CMD: begin
          if (rx_edge) begin
            byteIdx_d = '0;
            case (rxData)
              CMD_RD_PERIOD: begin
                txBuf_d  = periodCount;
                txData_d = periodCount[MEAS_WIDTH-1 -: 8];
                state_d  = ST_TX;
              end
              CMD_RD_HIGH: begin
                txBuf_d  = highCount;
                txData_d = highCount[MEAS_WIDTH-1 -: 8];
                state_d  = ST_TX;
              end
              CMD_STATUS: begin
                txData_d   = status_byte(measValid, measBusy, cmdError_q);
                cmdError_d = 1'b0;
                state_d    = ST_PAD;
              end
              CMD_WR_GATE: begin
                txData_d = '0;
                state_d  = ST_WR;
              end
              CMD_START: begin
                txData_d    = '0;
                measStart_d = 1'b1;
                state_d     = ST_PAD;
              end
              default: begin
                txData_d   = '0;
                cmdError_d = 1'b1;
                state_d    = ST_PAD;
              end
            endcase
          end
        end
        ST_TX: begin
          // The snapshot is shifted left so the next byte is always on top.
          if (rx_edge) begin
            txBuf_d = txBuf_q << 8;
            if (byteIdx_q == LAST_IDX) begin
              txData_d = '0;
              state_d  = ST_PAD;
            end else begin
              byteIdx_d = byteIdx_q + IDX_W'(1);
              txData_d  = txBuf_d[MEAS_WIDTH-1 -: 8];
            end
          end
        end
        ST_WR: begin
          if (rx_edge) begin
            gateSel_d = rxData;
            txData_d  = '0;
            state_d   = ST_PAD;
          end
        end
        ST_PAD: begin
          txData_d = '0;
        end
        default: begin
          state_d  = ST_IDLE;
          txData_d = '0;
        end
      endcase
    end
  end

  assign txData    = txData_q;
  assign gateSel   = gateSel_q;
  assign measStart = measStart_q;
  assign cmdError  = cmdError_q;

endmodule

// File: doc/spi_cmd_regs.md
# spi_cmd_regs

Command decoder and register bank behind the SPI slave of the pulse-measurement design. Consumes each byte received by the SPI slave (`rxData` plus its `rxStrobe` pulse) and decodes a one-byte command per chip-select frame. Supplies the next byte to shift out (`txData`): measurement results, status or padding. Holds the gate-select register and issues the measurement start pulse toward the pulse-measurement core.

## Interface
- `MEAS_WIDTH`, default 32: width of the period and high-time counts; must be a multiple of 8.
- `GATE_RESET`, default 8'h01: reset value of `gateSel`.

- `clk`  in  1  system clock; all logic is in this single domain.
- `rest`  in  1  asynchronous, active-low reset.
- `cs`  in  1  raw SPI chip select, active low; asynchronous to `clk`.
- `rxData`  in  8  last received byte; stable while `rxStrobe` is high.
- `rxStrobe`  in  1  byte-received pulse, 8 `clk` wide; one byte per rising edge.
- `txData`  out  8  byte sampled by the SPI slave at the first SCLK edge of the next byte.
- `periodCount`  in  MEAS_WIDTH  latest period count.
- `highCount`  in  MEAS_WIDTH  latest high-time count.
- `measValid`  in  1  counts are valid.
- `measBusy`  in  1  measurement in progress.
- `gateSel`  out  8  gate-time select register.
- `measStart`  out  1  single-cycle start pulse.
- `cmdError`  out  1  sticky flag: unknown command received.

## Operation
- `cs` passes through a 2-flop synchronizer giving `csS`. Rising edge of `rxStrobe` is detected with a 1-flop delay (`rxEdge`).
- FSM states:
  - IDLE: entered on reset and on every `csS` rising edge. Sets `txData` = 8'h00 and `byteIdx` = 0.
  - CMD: entered on a `csS` falling edge. The first `rxEdge` decodes `rxData`.
  - TX: streams `txBuf` out MSB-first, one byte per `rxEdge`.
  - WR: stores the next byte into `gateSel`.
  - PAD: `txData` = 8'h00 until the frame ends.
- Commands decoded in CMD:
  - 8'h01: `txBuf` <= `periodCount` snapshot; `txData` <= top byte; go to TX.
  - 8'h02: same as 8'h01 but using `highCount`.
  - 8'h03: `txData` <= {`measValid`, `measBusy`, 5'b0, `cmdError`}; then `cmdError` <= 0; go to PAD.
  - 8'h10: go to WR; `txData` = 8'h00.
  - 8'h20: `measStart` = 1 for exactly one `clk`; go to PAD.
  - Any other value: `cmdError` <= 1; go to PAD.
- TX: on each `rxEdge`, `byteIdx` increments and `txData` <= the next lower byte of `txBuf`. After MEAS_WIDTH/8 bytes have been presented, go to PAD.
- WR: on `rxEdge`, `gateSel` <= `rxData`; go to PAD. The written byte is not echoed.
- The snapshot is taken once per command, so later count changes never tear a multi-byte read.
- While `csS` = 1, every `rxEdge` is ignored.

## Timing
- Reset values: `txData` = 8'h00, `gateSel` = `GATE_RESET`, `measStart` = 0, `cmdError` = 0, FSM in IDLE.
- `txData` updates 2 `clk` cycles after the `rxStrobe` rising edge.
- The SPI slave adds about 3 `clk` of trigger latency. The master must therefore leave ≥ 8 `clk` between the last SCLK edge of one byte and the first SCLK edge of the next.
- `measStart` asserts 2 `clk` after the `rxStrobe` rising edge and lasts exactly 1 cycle.
- A `csS` rising edge in the same cycle as `rxEdge`: the frame end wins and the byte is discarded; `gateSel` is unchanged.
- Frame ending mid-TX or in WR: return to IDLE; `gateSel` is unchanged; no error.
- Commands 8'h03 and 8'h00 (unknown) in the same cycle as a new error: no conflict, because only one command is decoded per `rxEdge`.
- Reset asserted mid-frame: all state returns to reset values immediately. After reset releases, the first frame starts with `cs` high.

## Structure
- Shared package: command codes (`CMD_RD_PERIOD` = 8'h01, `CMD_RD_HIGH` = 8'h02, `CMD_STATUS` = 8'h03, `CMD_WR_GATE` = 8'h10, `CMD_START` = 8'h20), the FSM state encoding, and the status-byte bit positions.
- One sub-module, `sync_edge`: a 2-flop synchronizer with rise/fall outputs, used for `cs`. The `rxStrobe` edge detector uses the same module with its synchronizer depth set to 0.

## Test plan
- Frame: `cs` low, command 8'h01, 4 dummy bytes, with `periodCount` = 32'h12345678 → `txData` sequence 12, 34, 56, 78, then 00.
- Command 8'h02 with `highCount` changed to 32'hAABBCCDD after the command byte → bytes read back as the snapshot value from before the change.
- Command 8'h10 followed by 8'h05 → `gateSel` = 8'h05. A second frame with 8'h10 that ends before the data byte → `gateSel` stays 8'h05.
- Command 8'h20 → exactly one `measStart` cycle, 2 `clk` after the strobe edge. Command 8'h7E → `cmdError` = 1. Then 8'h03 with `measValid` = 1 and `measBusy` = 0 → `txData` = 8'h81, after which `cmdError` = 0.
- `rxStrobe` edge coincident with the `cs` rising edge during WR → `gateSel` unchanged and state IDLE.
- `rest` pulsed low mid-TX → all outputs at reset values and `gateSel` = 8'h01. The next frame with 8'h01 works normally.
